// File: rtl/slot_index_allocator.sv
// Free/used bitmap owner for a packet buffer: grants one slot index per cycle
// (lowest-first or round-robin) and absorbs up to NUM_FREE_PORTS releases per cycle.
`timescale 1ns/1ps
module slot_index_allocator #(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned NUM_FREE_PORTS = 2,
  parameter int unsigned ROUND_ROBIN    = 0,
  parameter int unsigned IDX_W          = $clog2(NUM_ENTRIES),
  parameter int unsigned CNT_W          = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc_req,
  output logic                              alloc_ready,
  output logic [IDX_W-1:0]                  alloc_index,
  input  logic [NUM_FREE_PORTS-1:0]         free_valid,
  input  logic [NUM_FREE_PORTS*IDX_W-1:0]   free_index,
  output logic [NUM_ENTRIES-1:0]            free_bitmap,
  output logic [CNT_W-1:0]                  free_count,
  output logic                              double_free_err
);

  logic [NUM_ENTRIES-1:0] bitmap_q, bitmap_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   err_q, err_d;

  logic [IDX_W-1:0]       start;
  logic                   any_found, hi_found;
  logic [IDX_W-1:0]       low_idx, hi_idx;
  logic                   grant;
  logic [NUM_ENTRIES-1:0] gnt_vec;
  logic [NUM_ENTRIES-1:0] rel_set;
  logic [CNT_W-1:0]       rel_cnt;
  logic [IDX_W-1:0]       fidx;

  // Search from registered state only: first free at/after start, else lowest free.
  always_comb begin
    start     = (ROUND_ROBIN != 0) ? ptr_q : '0;
    any_found = 1'b0;
    hi_found  = 1'b0;
    low_idx   = '0;
    hi_idx    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (bitmap_q[i] && !any_found) begin
        any_found = 1'b1;
        low_idx   = IDX_W'(i);
      end
      if (bitmap_q[i] && !hi_found && (i >= 32'(start))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    alloc_ready = |bitmap_q;
    alloc_index = hi_found ? hi_idx : low_idx;
  end

  // Releases: only used, in-range, not-yet-claimed indices count; anything else is an error.
  always_comb begin
    rel_set = '0;
    err_d   = 1'b0;
    fidx    = '0;
    for (int unsigned p = 0; p < NUM_FREE_PORTS; p++) begin
      if (free_valid[p]) begin
        fidx = free_index[p*IDX_W +: IDX_W];
        if (32'(fidx) >= NUM_ENTRIES) begin
          err_d = 1'b1;
        end else if (bitmap_q[fidx] || rel_set[fidx]) begin
          err_d = 1'b1;
        end else begin
          rel_set[fidx] = 1'b1;
        end
      end
    end
    rel_cnt = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      rel_cnt = rel_cnt + CNT_W'(rel_set[i]);
    end
  end

  // Next state; a granted bit is free in bitmap_q so it can never also be in rel_set.
  always_comb begin
    grant   = alloc_req && alloc_ready;
    gnt_vec = '0;
    if (grant) begin
      gnt_vec[alloc_index] = 1'b1;
    end
    bitmap_d = (bitmap_q & ~gnt_vec) | rel_set;
    count_d  = count_q - CNT_W'(grant) + rel_cnt;
    ptr_d    = ptr_q;
    if ((ROUND_ROBIN != 0) && grant) begin
      ptr_d = (32'(alloc_index) == NUM_ENTRIES - 1) ? '0 : alloc_index + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q <= '1;
      count_q  <= CNT_W'(NUM_ENTRIES);
      ptr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
    end
  end

  assign free_bitmap     = bitmap_q;
  assign free_count      = count_q;
  assign double_free_err = err_q;

endmodule

// File: doc/slot_index_allocator.md
Name: slot_index_allocator

Overview:
Sequential successor to the combinational next-free-index encoder. It owns the free/used bitmap of a packet buffer with NUM_ENTRIES slots and grants one slot index per cycle over a ready/request handshake. It accepts up to NUM_FREE_PORTS slot releases per cycle and supports lowest-first or round-robin search. It sits between the packet controller's ingress (allocation) and egress/retire paths (release).

Parameters:
NUM_ENTRIES, 8, number of buffer slots (any value >= 2, not required to be a power of two)
NUM_FREE_PORTS, 2, number of independent release ports
ROUND_ROBIN, 0, 0 = lowest free index first; 1 = search starts one past the last granted index
IDX_W, $clog2(NUM_ENTRIES), index width (derived, not overridden)
CNT_W, $clog2(NUM_ENTRIES+1), free-count width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alloc_req  in  1  requester wants a slot this cycle
alloc_ready  out  1  at least one slot free (registered bitmap non-zero)
alloc_index  out  IDX_W  index granted if alloc_req && alloc_ready this cycle
free_valid  in  NUM_FREE_PORTS  per-port release strobe
free_index  in  NUM_FREE_PORTS*IDX_W  packed release indices, port p at [p*IDX_W +: IDX_W]
free_bitmap  out  NUM_ENTRIES  registered bitmap, 1 = slot free
free_count  out  CNT_W  registered number of free slots
double_free_err  out  1  one-cycle registered error pulse

Behaviour:
- Reset (async assert, sync-to-clk release): free_bitmap all ones, free_count = NUM_ENTRIES, round-robin pointer = 0, double_free_err = 0.
- alloc_ready and alloc_index are combinational from registered state only; there is no path from free_* inputs.
- When alloc_ready = 0, alloc_index = 0.
- Lowest-first mode: alloc_index = lowest set bit of free_bitmap.
- Round-robin mode: alloc_index = first set bit at or after the pointer, wrapping modulo NUM_ENTRIES.
- Grant fires when alloc_req && alloc_ready. The granted bit clears at the next edge. In round-robin mode the pointer moves to (alloc_index+1) mod NUM_ENTRIES; wrap from NUM_ENTRIES-1 goes to 0. The pointer holds when there is no grant.
- alloc_req with alloc_ready = 0 is dropped. It is not queued and has no side effect.
- Release: a valid port whose index is currently used (bitmap bit 0) sets that bit at the next edge. There is no same-cycle bypass: a slot freed in cycle N is allocatable from cycle N+1.
- Full case: bitmap all zero plus a release in the same cycle gives alloc_ready = 0 in that cycle. No grant occurs that cycle.
- Release of an already-free index is ignored, and double_free_err is 1 in the next cycle.
- Release with index >= NUM_ENTRIES is ignored and also raises double_free_err.
- Two ports releasing the same used index in one cycle count as one release, plus double_free_err.
- Release of the index being granted in the same cycle cannot be legal, because that slot is still free in the registered state. It is treated as a double free: the grant proceeds and the error pulses.
- free_count_next = free_count - grant + number of distinct legal releases. It never exceeds NUM_ENTRIES and always equals popcount(free_bitmap). The bench checks this invariant every cycle.
- double_free_err is the OR of all error conditions for the cycle, registered. It is high for exactly one cycle per offending cycle.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of clk. Grants and releases in flight are discarded.

Test Plan:
1. Reset, NUM_ENTRIES=8, ROUND_ROBIN=0. Hold alloc_req for 8 cycles -> indices 0..7 granted in order; free_count steps 8->0; alloc_ready=0 from cycle 9 on; alloc_index=0 while not ready.
2. From full, free_valid[0]=1 with index 5 while alloc_req=1 -> no grant that cycle; next cycle alloc_ready=1, alloc_index=5; grant leaves free_count=0 again.
3. ROUND_ROBIN=1, all free. Grant 3 times (0,1,2), free index 0, grant again -> index 3, not 0. Grant until index 7 -> next grant wraps to 0.
4. Both ports in one cycle release used indices 2 and 6 while a grant fires -> free_count changes by +1; bitmap bits 2 and 6 set; granted bit cleared; no error.
5. Release an already-free index 4 -> bitmap unchanged; double_free_err high for exactly 1 cycle. Both ports release the same used index 3 -> free_count +1 only, plus error pulse.
6. NUM_ENTRIES=6: release index 7 -> ignored with error. Assert rst_n low between clock edges mid-sequence -> bitmap 6'b111111 and free_count=6 immediately, before the next edge.
